// File: rtl/branch_status_unit.sv
// Status register fed by the ALU plus a program counter that either increments
// or takes PC-relative conditional branches through an IDLE/EVAL/COMMIT sequencer.
module branch_status_unit #(
  parameter int          PC_W   = 9,
  parameter int unsigned RST_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      Z_in,
  input  logic            loads,
  input  logic            br_valid,
  input  logic [2:0]      cond,
  input  logic [7:0]      imm8,
  input  logic            pc_inc,
  output logic            br_ready,
  output logic            br_done,
  output logic            br_taken,
  output logic [2:0]      status_out,
  output logic [PC_W-1:0] pc_out
);

  typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [PC_W-1:0] PC_RST = PC_W'(RST_PC);

  state_t             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    target_q;
  logic [2:0]         status_q;
  logic [2:0]         cond_q;
  logic signed [7:0]  imm_q;
  logic               taken_q;
  logic               ready_q;
  logic               done_q;

  logic [PC_W-1:0]    pc_plus1_d;
  logic [PC_W-1:0]    target_d;
  logic               taken_d;

  // Status bits: [0] zero, [1] negative, [2] overflow. Codes 101-111 are reserved.
  function automatic logic cond_met(input logic [2:0] c, input logic [2:0] s);
    logic z, n, v;
    z = s[0];
    n = s[1];
    v = s[2];
    case (c)
      3'b000:  cond_met = 1'b1;
      3'b001:  cond_met = z;
      3'b010:  cond_met = ~z;
      3'b011:  cond_met = n ^ v;
      3'b100:  cond_met = (n ^ v) | z;
      default: cond_met = 1'b0;
    endcase
  endfunction

  always_comb begin
    pc_plus1_d = pc_q + PC_ONE;
    target_d   = pc_plus1_d + PC_W'(imm_q);
    taken_d    = cond_met(cond_q, status_q);
  end

  // Decision in EVAL reads status_q before any load on the same edge lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= PC_RST;
      target_q <= '0;
      status_q <= '0;
      cond_q   <= '0;
      imm_q    <= '0;
      taken_q  <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      if (loads) status_q <= Z_in;
      unique case (state_q)
        IDLE: begin
          if (br_valid) begin
            cond_q  <= cond;
            imm_q   <= $signed(imm8);
            ready_q <= 1'b0;
            state_q <= EVAL;
          end else if (pc_inc) begin
            pc_q <= pc_plus1_d;
          end
        end
        EVAL: begin
          taken_q  <= taken_d;
          target_q <= target_d;
          done_q   <= 1'b1;
          state_q  <= COMMIT;
        end
        COMMIT: begin
          pc_q    <= taken_q ? target_q : pc_plus1_d;
          taken_q <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign br_ready   = ready_q;
  assign br_done    = done_q;
  assign br_taken   = taken_q;
  assign status_out = status_q;
  assign pc_out     = pc_q;

endmodule
